// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the two-requester arbiter (master) and a single APB slave.
interface apb_master_arb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master with one outstanding transfer
// and an ACCESS-phase timeout that reports an error response.
module apb_master_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req0_valid,
  input  logic               req0_write,
  input  logic [31:0]        req0_addr,
  input  logic [31:0]        req0_wdata,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic               req1_write,
  input  logic [31:0]        req1_addr,
  input  logic [31:0]        req1_wdata,
  output logic               req1_ready,
  output logic               rsp0_valid,
  output logic [31:0]        rsp0_rdata,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  output logic [31:0]        rsp1_rdata,
  output logic               rsp1_err,
  apb_master_arb_if.master   apb,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt0, gnt1;

  // Tie goes to whichever requester was not granted last.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && !gnt0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          grant_d = gnt1;
          last_d  = gnt1;
          write_d = gnt1 ? req1_write : req0_write;
          addr_d  = gnt1 ? req1_addr : req0_addr;
          if (gnt1) wdata_d = req1_write ? req1_wdata : 32'h0;
          else      wdata_d = req0_write ? req0_wdata : 32'h0;
          cnt_d   = 8'd0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PSLVERR only matters in the completing cycle.
        if (apb.PREADY) begin
          rdata_d = write_q ? 32'h0 : apb.PRDATA;
          err_d   = apb.PSLVERR;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus controls and responses decode from registers only.
  assign apb.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb.PENABLE = (state_q == ACCESS);
  assign apb.PWRITE  = write_q;
  assign apb.PADDR   = addr_q;
  assign apb.PWDATA  = wdata_q;
  assign apb.PSTRB   = write_q ? 4'hF : 4'h0;

  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) && grant_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 32'h0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 32'h0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: latency, round-robin, wait states,
// timeout, slave error and mid-transfer reset.
module tb_apb_master_arb;

  logic        PCLK;
  logic        PRESETn;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        busy;
  logic        pready_tb, pslverr_tb, rd_ovr_en;
  logic [31:0] rd_ovr;
  int          n_checks, n_fail;

  apb_master_arb_if bus();

  // Slave model: read data is the address XOR a tag unless overridden.
  assign bus.PRDATA  = rd_ovr_en ? rd_ovr : (bus.PADDR ^ 32'hCAFE_0000);
  assign bus.PREADY  = pready_tb;
  assign bus.PSLVERR = pslverr_tb;

  apb_master_arb #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .apb(bus), .busy(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task test_reset;
    PRESETn = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    pready_tb = 1; pslverr_tb = 0; rd_ovr_en = 0; rd_ovr = 0;
    #1 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, busy});
    end
    n_checks++;
    if ({bus.PADDR, bus.PWDATA} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 0", bus.PADDR, bus.PWDATA);
    end
    n_checks++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, rsp0_rdata, rsp1_rdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v0 %b v1 %b expected 0", rsp0_valid, rsp1_valid);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task test_write;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 1; req0_addr = 32'h4; req0_wdata = 32'hA5A5_0001;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_ready: got %b expected 01", {req1_ready, req0_ready});
    end
    @(negedge PCLK);
    req0_valid = 0;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h30; req1_wdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, req1_ready} !== 8'b1011_1110) begin
      n_fail++;
      $display("FAIL write_setup: got %b expected 10111110", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, req1_ready});
    end
    n_checks++;
    if ({bus.PADDR, bus.PWDATA} !== {32'h4, 32'hA5A5_0001}) begin
      n_fail++;
      $display("FAIL write_setup_bus: got %h %h expected 00000004 a5a50001", bus.PADDR, bus.PWDATA);
    end
    @(negedge PCLK); #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, req1_ready, bus.PADDR} !== {3'b110, 32'h4}) begin
      n_fail++;
      $display("FAIL write_access: got %b addr %h expected 110 addr 00000004", {bus.PSEL, bus.PENABLE, req1_ready}, bus.PADDR);
    end
    @(negedge PCLK); #1;
    n_checks++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, bus.PSEL, req1_ready, rsp0_rdata} !== {5'b10000, 32'h0}) begin
      n_fail++;
      $display("FAIL write_rsp: got %b rdata %h expected 10000 rdata 0", {rsp0_valid, rsp0_err, rsp1_valid, bus.PSEL, req1_ready}, rsp0_rdata);
    end
    $display("txn: req0 write addr 00000004 rsp err=%b", rsp0_err);
  endtask

  task test_back_to_back;
    logic got;
    @(negedge PCLK); #1;
    n_checks++;
    if ({req1_ready, rsp0_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_accept_cycle4: got %b expected 100", {req1_ready, rsp0_valid, busy});
    end
    @(negedge PCLK);
    req1_valid = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge PCLK); #1;
      got = rsp1_valid;
    end
    n_checks++;
    if ({got, rsp0_valid, rsp1_err, rsp1_rdata} !== {3'b100, 32'hCAFE_0030}) begin
      n_fail++;
      $display("FAIL b2b_rsp1: got %b rdata %h expected 100 rdata cafe0030", {got, rsp0_valid, rsp1_err}, rsp1_rdata);
    end
    $display("txn: req1 read addr 00000030 rdata %h", rsp1_rdata);
  endtask

  task test_round_robin;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h20;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_sel  = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (t % 2 == 0) ? 32'hCAFE_0010 : 32'hCAFE_0020;
      for (int k = 0; k < 8; k++) begin
        if (req0_ready || req1_ready) break;
        @(negedge PCLK); #1;
      end
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_sel) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b expected %b", t, {req1_ready, req0_ready}, exp_sel);
      end
      if (t == 3) begin
        @(negedge PCLK);
        req0_valid = 0; req1_valid = 0;
      end
      for (int k = 0; k < 8; k++) begin
        @(negedge PCLK); #1;
        if (rsp0_valid || rsp1_valid) break;
      end
      n_checks++;
      if ({rsp1_valid, rsp0_valid} !== exp_sel) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: got %b expected %b", t, {rsp1_valid, rsp0_valid}, exp_sel);
      end
      n_checks++;
      if ((rsp0_rdata | rsp1_rdata) !== exp_data || (rsp0_rdata != 32'h0 && rsp1_rdata != 32'h0)) begin
        n_fail++;
        $display("FAIL rr_data%0d: got r0 %h r1 %h expected %h on one side", t, rsp0_rdata, rsp1_rdata, exp_data);
      end
      $display("txn: rr %0d rsp sel %b r0 %h r1 %h", t, {rsp1_valid, rsp0_valid}, rsp0_rdata, rsp1_rdata);
    end
  endtask

  task test_wait_states;
    rd_ovr_en = 1; rd_ovr = 32'h1234;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 0; req0_addr = 32'h40;
    @(negedge PCLK);
    req0_valid = 0; pready_tb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (i == 3) pready_tb = 1;
      #1;
      n_checks++;
      if ({bus.PSEL, bus.PENABLE, rsp0_valid, bus.PADDR} !== {3'b110, 32'h40}) begin
        n_fail++;
        $display("FAIL wait_access%0d: got %b addr %h expected 110 addr 00000040", i, {bus.PSEL, bus.PENABLE, rsp0_valid}, bus.PADDR);
      end
    end
    @(negedge PCLK); #1;
    n_checks++;
    if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b10, 32'h1234}) begin
      n_fail++;
      $display("FAIL wait_rsp: got %b rdata %h expected 10 rdata 00001234", {rsp0_valid, rsp0_err}, rsp0_rdata);
    end
    $display("txn: req0 read addr 00000040 (3 waits) rdata %h", rsp0_rdata);
    rd_ovr_en = 0;
  endtask

  task test_timeout;
    logic got;
    rd_ovr_en = 1; rd_ovr = 32'hDEAD_BEEF;
    @(negedge PCLK);
    req1_valid = 1; req1_write = 0; req1_addr = 32'h80;
    @(negedge PCLK);
    req1_valid = 0; pready_tb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK); #1;
      n_checks++;
      if ({bus.PSEL, bus.PENABLE, rsp1_valid} !== 3'b110) begin
        n_fail++;
        $display("FAIL timeout_access%0d: got %b expected 110", i, {bus.PSEL, bus.PENABLE, rsp1_valid});
      end
    end
    @(negedge PCLK); #1;
    n_checks++;
    if ({rsp1_valid, rsp1_err, rsp0_valid, bus.PSEL, rsp1_rdata} !== {4'b1100, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_rsp: got %b rdata %h expected 1100 rdata 0", {rsp1_valid, rsp1_err, rsp0_valid, bus.PSEL}, rsp1_rdata);
    end
    $display("txn: req1 read addr 00000080 timeout err=%b", rsp1_err);
    pready_tb = 1; rd_ovr_en = 0;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 1; req0_addr = 32'hC; req0_wdata = 32'h5555;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next_ready: got %b expected 1", req0_ready);
    end
    @(negedge PCLK);
    req0_valid = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge PCLK); #1;
      got = rsp0_valid;
    end
    n_checks++;
    if ({got, rsp0_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_next_rsp: got %b expected 10", {got, rsp0_err});
    end
    $display("txn: req0 write addr 0000000c after timeout err=%b", rsp0_err);
  endtask

  task test_slverr;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 1; req0_addr = 32'h8; req0_wdata = 32'h1;
    @(negedge PCLK);
    req0_valid = 0;
    @(negedge PCLK);
    pready_tb = 0; pslverr_tb = 1;
    @(negedge PCLK);
    pready_tb = 1; pslverr_tb = 0;
    #1;
    n_checks++;
    if ({bus.PENABLE, rsp0_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL slverr_ignored_access: got %b expected 10", {bus.PENABLE, rsp0_valid});
    end
    @(negedge PCLK); #1;
    n_checks++;
    if ({rsp0_valid, rsp0_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL slverr_ignored_rsp: got %b expected 10", {rsp0_valid, rsp0_err});
    end
    $display("txn: req0 write addr 00000008 stray pslverr err=%b", rsp0_err);
    pslverr_tb = 1;
    @(negedge PCLK);
    req0_valid = 1;
    @(negedge PCLK);
    req0_valid = 0;
    @(negedge PCLK);
    @(negedge PCLK); #1;
    n_checks++;
    if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL slverr_rsp: got %b rdata %h expected 11 rdata 0", {rsp0_valid, rsp0_err}, rsp0_rdata);
    end
    $display("txn: req0 write addr 00000008 pslverr err=%b", rsp0_err);
    pslverr_tb = 0;
  endtask

  task test_reset_mid;
    logic got;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 0; req0_addr = 32'h100;
    @(negedge PCLK);
    req0_valid = 0; pready_tb = 0;
    @(negedge PCLK); #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_access: got %b expected 11", {bus.PSEL, bus.PENABLE});
    end
    PRESETn = 0;
    #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_drop: got %b expected 000", {bus.PSEL, bus.PENABLE, busy});
    end
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1; pready_tb = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      n_checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_no_rsp%0d: got %b expected 000", i, {rsp0_valid, rsp1_valid, busy});
      end
    end
    @(negedge PCLK);
    req0_valid = 1; req0_write = 0; req0_addr = 32'h200;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h300;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_tie: got %b expected 01", {req1_ready, req0_ready});
    end
    @(negedge PCLK);
    req0_valid = 0; req1_valid = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge PCLK); #1;
      got = rsp0_valid | rsp1_valid;
    end
    n_checks++;
    if ({rsp1_valid, rsp0_valid, rsp0_rdata} !== {2'b01, 32'hCAFE_0200}) begin
      n_fail++;
      $display("FAIL rstmid_post_rsp: got %b rdata %h expected 01 rdata cafe0200", {rsp1_valid, rsp0_valid}, rsp0_rdata);
    end
    $display("txn: post-reset tie req0 read addr 00000200 rdata %h", rsp0_rdata);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_write;
    test_back_to_back;
    test_round_robin;
    test_wait_states;
    test_timeout;
    test_slverr;
    test_reset_mid;
    repeat (2) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter TIMEOUT, default 16, number of ACCESS cycles without PREADY before abort; legal range 1..255.
REQ-002 PCLK  in  1  APB clock; all state updates on rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-004 reqN_valid  in  1  requester N (N=0,1) transfer request; held with payload until accepted.
REQ-005 reqN_write  in  1  1=write, 0=read.
REQ-006 reqN_addr  in  32  byte address.
REQ-007 reqN_wdata  in  32  write data.
REQ-008 reqN_ready  out  1  request accepted when reqN_valid and reqN_ready are both high.
REQ-009 rspN_valid  out  1  one-cycle completion pulse to requester N.
REQ-010 rspN_rdata  out  32  read data, valid with rspN_valid.
REQ-011 rspN_err  out  1  slave error or timeout, valid with rspN_valid.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-013 PADDR, PWDATA  out  32 each; PSTRB  out  4.
REQ-014 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-017 IDLE: reqN_ready SHALL be high combinationally only for the granted requester; on acceptance, latch write/addr/wdata and grant index, clear timeout counter, go to SETUP.
REQ-018 Arbitration SHALL be round-robin: one valid requester wins; if both are valid, the requester not granted last wins; the last-grant pointer updates on acceptance only.
REQ-019 SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle.
REQ-020 ACCESS: PSEL=1 and PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS.
REQ-021 ACCESS with PREADY=1: capture PRDATA for reads (0 for writes) and PSLVERR into response registers, then go to RESP.
REQ-022 ACCESS with PREADY=0: increment the counter; when TIMEOUT ACCESS cycles have elapsed without PREADY, set err=1 and rdata=0, then go to RESP.
REQ-023 PSLVERR SHALL be sampled only in the ACCESS cycle where PREADY=1 and ignored otherwise.
REQ-024 RESP: rspN_valid=1 for exactly one cycle, only for the latched grant index; PSEL=0; go to IDLE.
REQ-025 PSEL, PENABLE and rspN_valid SHALL decode from the state register only, with no combinational path from APB inputs.
REQ-026 PSTRB SHALL be 4'hF on writes and 4'h0 on reads; PWDATA SHALL be 0 on reads.
REQ-027 With a zero-wait slave, latency SHALL be: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp pulse cycle 3; the next acceptance is no earlier than cycle 4.
REQ-028 A request arriving during a non-IDLE state SHALL wait with ready=0 and no loss.
REQ-029 Only one transfer SHALL be outstanding at a time; the non-granted requester's response outputs stay 0.

Reset
REQ-030 While PRESETn=0: state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp*, busy and counter all 0; last-grant pointer=1, so req0 wins the first tie.
REQ-031 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately, with no response pulse afterward.

Verification
REQ-032 req0 write addr 0x4, data 0xA5A5_0001, PREADY tied 1 -> PSEL cycles 1-2, PENABLE cycle 2, PSTRB=F, rsp0_valid cycle 3 with err=0.
REQ-033 req0 and req1 reads issued together twice -> grant order 0,1,0,1; each rsp carries its own PRDATA; no cross-delivery.
REQ-034 Read with PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234 -> PADDR stable throughout, rsp rdata=0x1234, ACCESS lasts 4 cycles.
REQ-035 TIMEOUT=4, PREADY held 0 -> after 4 ACCESS cycles, RESP with err=1, rdata=0; the next request proceeds normally.
REQ-036 PREADY=1 with PSLVERR=1 on a write -> rsp_err=1; PSLVERR pulse while PREADY=0 -> ignored.
REQ-037 PRESETn pulsed low during ACCESS -> PSEL=0 at once, no rsp pulse, and the first post-reset tie is granted to req0.
